// File: rtl/reference_sweep_ctrl.sv
// Sweeps a circular index range into a reference buffer and waits for every issued index to return.
// Index valid is registered; done one cycle after the final return; s_ready stalls issue, 4 silent drain cycles abort with error.
module reference_sweep_ctrl #(
    parameter int buffer_length = 10,
    parameter int index_bits    = 4,
    parameter int len_bits      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [index_bits-1:0] start_index,
    input  logic [len_bits-1:0]   sweep_len,
    input  logic                  s_ready,
    input  logic                  s_axi_data_rvalid,
    output logic                  m_axi_rready,
    output logic                  m_axi_index_rvalid,
    output logic [index_bits-1:0] m_axi_index_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int unsigned BUF_LEN = buffer_length;
    localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);

    state_t              state, state_nxt;
    logic [len_bits-1:0] len_q, issued, returned;
    logic [1:0]          silence;
    logic                hs, ret, start_ok, start_go, start_bad;
    logic                last_hs, all_returned, timeout;

    assign m_axi_rready = s_ready;
    assign busy         = (state == ISSUE) || (state == DRAIN);
    assign done         = (state == DONE);

    assign hs        = m_axi_index_rvalid & s_ready;
    assign ret       = s_axi_data_rvalid & busy;
    assign start_ok  = (32'(start_index) < BUF_LEN) && (sweep_len != '0);
    assign start_go  = (state == IDLE) && start && start_ok && !abort;
    assign start_bad = (state == IDLE) && start && !start_ok && !abort;
    assign last_hs   = hs && (issued == len_q - len_bits'(1));
    // The final return may land on the same edge that closes the drain.
    assign all_returned = (returned == len_q) ||
                          (s_axi_data_rvalid && (returned == len_q - len_bits'(1)));
    assign timeout   = !s_axi_data_rvalid && (silence == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_go) state_nxt = ISSUE;
            ISSUE: if (last_hs) state_nxt = DRAIN;
            DRAIN: begin
                if (all_returned) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axi_index_rvalid <= 1'b0;
            m_axi_index_rdata  <= '0;
            len_q              <= '0;
            issued             <= '0;
            returned           <= '0;
            silence            <= '0;
            error              <= 1'b0;
        end else begin
            m_axi_index_rvalid <= (state_nxt == ISSUE);
            error <= !abort && (start_bad ||
                     ((state == DRAIN) && timeout && !all_returned));

            if (start_go) begin
                m_axi_index_rdata <= start_index;
                len_q             <= sweep_len;
                issued            <= '0;
                returned          <= '0;
            end else begin
                if (hs && (state == ISSUE)) begin
                    m_axi_index_rdata <= (m_axi_index_rdata == LAST_IDX) ?
                                         '0 : m_axi_index_rdata + index_bits'(1);
                    issued <= issued + len_bits'(1);
                end
                if (ret && (returned != len_q)) begin
                    returned <= returned + len_bits'(1);
                end
            end

            // Silence only accumulates while draining; any return restarts the window.
            if ((state != DRAIN) || s_axi_data_rvalid) begin
                silence <= '0;
            end else if (silence != 2'd3) begin
                silence <= silence + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_reference_sweep_ctrl.sv
// Bench for reference_sweep_ctrl: scoreboarded index issue with a 2-cycle buffer return model.
module tb_reference_sweep_ctrl;
    localparam int BL = 10;
    localparam int IB = 4;
    localparam int LB = 5;

    logic          clk = 1'b0;
    logic          rst, start, abort, s_ready, s_axi_data_rvalid;
    logic [IB-1:0] start_index;
    logic [LB-1:0] sweep_len;
    logic          m_axi_rready, m_axi_index_rvalid, busy, done, error;
    logic [IB-1:0] m_axi_index_rdata;

    reference_sweep_ctrl #(.buffer_length(BL), .index_bits(IB), .len_bits(LB)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .start_index(start_index), .sweep_len(sweep_len),
        .s_ready(s_ready), .s_axi_data_rvalid(s_axi_data_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_index_rvalid(m_axi_index_rvalid),
        .m_axi_index_rdata(m_axi_index_rdata),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int bad_cnt = 0;
    int cyc = 0;
    int exp_q[$];
    int obs_q[$];
    int obs_edge[$];
    int done_cnt, done_cyc, err_cnt, err_cyc, last_ret_edge, ret_budget;
    logic [1:0] pipe;

    // One clock: record a pending handshake, drive the buffer return, then sample outputs at negedge.
    task automatic step();
        logic hs_now;
        hs_now = m_axi_index_rvalid && s_ready && !rst;
        if (hs_now) begin
            obs_q.push_back(int'(m_axi_index_rdata));
            obs_edge.push_back(cyc + 1);
        end
        s_axi_data_rvalid = pipe[1] && (ret_budget > 0);
        if (s_axi_data_rvalid) begin
            ret_budget--;
            last_ret_edge = cyc + 1;
        end
        pipe = {pipe[0], hs_now};
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (error) begin err_cnt++; err_cyc = cyc; end
    endtask

    task automatic clear();
        exp_q.delete(); obs_q.delete(); obs_edge.delete();
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
        last_ret_edge = -1; ret_budget = 0; pipe = 2'b00;
        s_axi_data_rvalid = 1'b0;
    endtask

    task automatic launch(input int si, input int len, input int budget);
        start_index = IB'(si);
        sweep_len   = LB'(len);
        ret_budget  = budget;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_until_end(input int limit);
        for (int i = 0; i < limit && done_cnt == 0 && err_cnt == 0; i++) step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_ready = 1'b0;
        start_index = '0; sweep_len = '0;
        clear();
        #12;
        cmp_cnt++; if (m_axi_index_rvalid !== 1'b0) begin bad_cnt++; $display("FAIL reset_rvalid: got %b want 0", m_axi_index_rvalid); end
        cmp_cnt++; if (m_axi_index_rdata !== '0) begin bad_cnt++; $display("FAIL reset_rdata: got %0d want 0", m_axi_index_rdata); end
        cmp_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        cmp_cnt++; if (done !== 1'b0) begin bad_cnt++; $display("FAIL reset_done: got %b want 0", done); end
        cmp_cnt++; if (error !== 1'b0) begin bad_cnt++; $display("FAIL reset_error: got %b want 0", error); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e, o, start_edge;
        clear();
        s_ready = 1'b1;
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        launch(0, 10, 100);
        start_edge = cyc;
        run_until_end(40);
        cmp_cnt++; if (obs_edge.size() != 10) begin bad_cnt++; $display("FAIL basic_hs_count: got %0d want 10", obs_edge.size()); end
        else begin
            cmp_cnt++; if (obs_edge[0] != start_edge + 1) begin bad_cnt++; $display("FAIL basic_first_latency: got edge %0d want %0d", obs_edge[0], start_edge + 1); end
            cmp_cnt++; if (obs_edge[9] != start_edge + 10) begin bad_cnt++; $display("FAIL basic_consecutive: got edge %0d want %0d", obs_edge[9], start_edge + 10); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL basic_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL basic_idx: got %0d want %0d", o, e); end end
        end
        cmp_cnt++; if (done_cnt != 1) begin bad_cnt++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        cmp_cnt++; if (done_cyc != last_ret_edge) begin bad_cnt++; $display("FAIL basic_done_latency: got edge %0d want %0d", done_cyc, last_ret_edge); end
        cmp_cnt++; if (err_cnt != 0) begin bad_cnt++; $display("FAIL basic_error: got %0d want 0", err_cnt); end
        cmp_cnt++; if (busy !== 1'b0) begin bad_cnt++; $display("FAIL basic_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        int e, o;
        clear();
        s_ready = 1'b1;
        for (int i = 0; i < 6; i++) exp_q.push_back((7 + i) % BL);
        launch(7, 6, 100);
        run_until_end(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL wrap_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL wrap_idx: got %0d want %0d", o, e); end end
        end
        cmp_cnt++; if (obs_q.size() != 0) begin bad_cnt++; $display("FAIL wrap_extra: got %0d extra want 0", obs_q.size()); end
        cmp_cnt++; if (done_cnt != 1) begin bad_cnt++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_ready_toggle();
        int e, o;
        clear();
        s_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        launch(0, 4, 100);
        step();
        s_ready = 1'b0;
        step();
        cmp_cnt++; if (m_axi_index_rvalid !== 1'b1 || m_axi_index_rdata !== 4'd1) begin bad_cnt++; $display("FAIL stall_hold1: got v=%b idx=%0d want v=1 idx=1", m_axi_index_rvalid, m_axi_index_rdata); end
        step();
        cmp_cnt++; if (m_axi_index_rvalid !== 1'b1 || m_axi_index_rdata !== 4'd1) begin bad_cnt++; $display("FAIL stall_hold2: got v=%b idx=%0d want v=1 idx=1", m_axi_index_rvalid, m_axi_index_rdata); end
        s_ready = 1'b1;
        run_until_end(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL stall_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL stall_idx: got %0d want %0d", o, e); end end
        end
        cmp_cnt++; if (obs_q.size() != 0) begin bad_cnt++; $display("FAIL stall_dup: got %0d extra want 0", obs_q.size()); end
        cmp_cnt++; if (done_cnt != 1) begin bad_cnt++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reject();
        clear();
        s_ready = 1'b1;
        launch(12, 3, 0);
        cmp_cnt++; if (error !== 1'b1) begin bad_cnt++; $display("FAIL reject_idx_error: got %b want 1", error); end
        cmp_cnt++; if (busy !== 1'b0 || m_axi_index_rvalid !== 1'b0) begin bad_cnt++; $display("FAIL reject_idx_idle: got busy=%b v=%b want 0 0", busy, m_axi_index_rvalid); end
        step();
        cmp_cnt++; if (error !== 1'b0) begin bad_cnt++; $display("FAIL reject_idx_pulse: got %b want 0", error); end
        launch(2, 0, 0);
        cmp_cnt++; if (error !== 1'b1) begin bad_cnt++; $display("FAIL reject_len_error: got %b want 1", error); end
        cmp_cnt++; if (busy !== 1'b0 || m_axi_index_rvalid !== 1'b0) begin bad_cnt++; $display("FAIL reject_len_idle: got busy=%b v=%b want 0 0", busy, m_axi_index_rvalid); end
        step();
        step();
        cmp_cnt++; if (err_cnt != 2 || obs_q.size() != 0 || done_cnt != 0) begin bad_cnt++; $display("FAIL reject_totals: got err=%0d hs=%0d done=%0d want 2 0 0", err_cnt, obs_q.size(), done_cnt); end
    endtask

    task automatic test_timeout();
        clear();
        s_ready = 1'b1;
        launch(0, 5, 3);
        run_until_end(40);
        cmp_cnt++; if (err_cnt != 1) begin bad_cnt++; $display("FAIL timeout_error: got %0d want 1", err_cnt); end
        cmp_cnt++; if (err_cyc != last_ret_edge + 4) begin bad_cnt++; $display("FAIL timeout_latency: got edge %0d want %0d", err_cyc, last_ret_edge + 4); end
        cmp_cnt++; if (done_cnt != 0) begin bad_cnt++; $display("FAIL timeout_done: got %0d want 0", done_cnt); end
        cmp_cnt++; if (busy !== 1'b0 || m_axi_index_rvalid !== 1'b0) begin bad_cnt++; $display("FAIL timeout_idle: got busy=%b v=%b want 0 0", busy, m_axi_index_rvalid); end
    endtask

    task automatic test_abort();
        int e, o;
        clear();
        s_ready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(i);
        launch(0, 8, 100);
        step();
        step();
        abort = 1'b1;
        step();
        cmp_cnt++; if (m_axi_index_rvalid !== 1'b0 || busy !== 1'b0) begin bad_cnt++; $display("FAIL abort_stop: got v=%b busy=%b want 0 0", m_axi_index_rvalid, busy); end
        abort = 1'b0;
        repeat (6) step();
        cmp_cnt++; if (done_cnt != 0 || err_cnt != 0) begin bad_cnt++; $display("FAIL abort_pulses: got done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL abort_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL abort_idx: got %0d want %0d", o, e); end end
        end
        clear();
        for (int i = 0; i < 3; i++) exp_q.push_back(4 + i);
        launch(4, 3, 100);
        run_until_end(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL abort_restart_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL abort_restart_idx: got %0d want %0d", o, e); end end
        end
        cmp_cnt++; if (done_cnt != 1) begin bad_cnt++; $display("FAIL abort_restart_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        int e, o;
        clear();
        s_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(1);
        launch(0, 8, 100);
        step();
        step();
        rst = 1'b1;
        #1;
        cmp_cnt++; if (m_axi_index_rvalid !== 1'b0 || m_axi_index_rdata !== '0 || busy !== 1'b0) begin bad_cnt++; $display("FAIL rst_async: got v=%b idx=%0d busy=%b want 0 0 0", m_axi_index_rvalid, m_axi_index_rdata, busy); end
        step();
        rst = 1'b0;
        pipe = 2'b00;
        repeat (4) step();
        cmp_cnt++; if (done_cnt != 0 || err_cnt != 0) begin bad_cnt++; $display("FAIL rst_pulses: got done=%0d err=%0d want 0 0", done_cnt, err_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL rst_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL rst_idx: got %0d want %0d", o, e); end end
        end
        clear();
        exp_q.push_back(9);
        exp_q.push_back(0);
        launch(9, 2, 100);
        run_until_end(40);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_cnt++;
            if (obs_q.size() == 0) begin bad_cnt++; $display("FAIL rst_restart_idx: got none want %0d", e); end
            else begin o = obs_q.pop_front(); if (o !== e) begin bad_cnt++; $display("FAIL rst_restart_idx: got %0d want %0d", o, e); end end
        end
        cmp_cnt++; if (done_cnt != 1) begin bad_cnt++; $display("FAIL rst_restart_done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        s_axi_data_rvalid = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_ready_toggle();
        test_reject();
        test_timeout();
        test_abort();
        test_mid_reset();
        cmp_cnt++; if (m_axi_rready !== s_ready) begin bad_cnt++; $display("FAIL rready_passthru: got %b want %b", m_axi_rready, s_ready); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end
endmodule
